// File: rtl/sa_matmul_pkg.sv
// Shared types and width helpers for the systolic matrix-multiply block.
package sa_matmul_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

  // Accumulator must hold KMAX full-width products without overflow.
  function automatic int aw_f(input int dw, input int kmax);
    return 2 * dw + $clog2(kmax);
  endfunction

  function automatic int kw_f(input int kmax);
    return $clog2(kmax + 1);
  endfunction

endpackage

// File: rtl/sa_matmul_pe.sv
// One processing element: forwards a right and b down one cycle later and
// accumulates a*b whenever both operands carry a valid tag.
module sa_pe #(
  parameter int DW     = 16,
  parameter int AW     = 38,
  parameter int SIGNED = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  logic          av_i,
  input  logic          bv_i,
  output logic [DW-1:0] a_o,
  output logic [DW-1:0] b_o,
  output logic          av_o,
  output logic          bv_o,
  output logic [AW-1:0] acc_o
);

  logic [DW-1:0]   a_q, a_d, b_q, b_d;
  logic            av_q, av_d, bv_q, bv_d;
  logic [AW-1:0]   acc_q, acc_d, prod_x;
  logic [2*DW-1:0] a_x, b_x, prod;
  logic            ext;

  always_comb begin
    ext    = (SIGNED != 0);
    // Extending to 2*DW first makes the low 2*DW product bits correct for both signednesses.
    a_x    = {{DW{ext & a_i[DW-1]}}, a_i};
    b_x    = {{DW{ext & b_i[DW-1]}}, b_i};
    prod   = a_x * b_x;
    prod_x = {{(AW-2*DW){ext & prod[2*DW-1]}}, prod};
    a_d    = a_i;
    b_d    = b_i;
    av_d   = av_i;
    bv_d   = bv_i;
    acc_d  = acc_q;
    if (clr)               acc_d = '0;
    else if (av_i && bv_i) acc_d = acc_q + prod_x;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q   <= '0;
      b_q   <= '0;
      av_q  <= 1'b0;
      bv_q  <= 1'b0;
      acc_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      av_q  <= av_d;
      bv_q  <= bv_d;
      acc_q <= acc_d;
    end
  end

  assign a_o   = a_q;
  assign b_o   = b_q;
  assign av_o  = av_q;
  assign bv_o  = bv_q;
  assign acc_o = acc_q;

endmodule

// File: rtl/sa_matmul.sv
// NxN output-stationary systolic matrix multiplier: operand skew, PE grid,
// job FSM and a registered row-by-row result drain.
module sa_matmul
  import sa_matmul_pkg::*;
#(
  parameter int N      = 4,
  parameter int DW     = 16,
  parameter int KMAX   = 64,
  parameter int SIGNED = 0,
  parameter int AW     = aw_f(DW, KMAX),
  parameter int KW     = kw_f(KMAX),
  parameter int RW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [KW-1:0]   k_len,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] a_col,
  input  logic [N*DW-1:0] b_row,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*AW-1:0] out_data,
  output logic [RW-1:0]   out_row,
  output logic            busy,
  output logic            done
);

  localparam int FW = $clog2(2 * N);

  state_t                      state_q, state_d;
  logic [KW-1:0]               klen_q, klen_d, kcnt_q, kcnt_d, klen_sat;
  logic [FW-1:0]               fcnt_q, fcnt_d;
  logic [RW-1:0]               row_q, row_d, row_nx;
  logic                        in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic                        busy_q, busy_d, done_q, done_d;
  logic [N-1:0][AW-1:0]        out_data_q, out_data_d;
  logic                        accept, clr;

  logic [N-1:0][DW-1:0]        a_in_q, b_in_q, a_sk, b_sk;
  logic                        v_in_q;
  logic [N-1:0]                v_sk;
  logic [N-1:0][N-1:0][DW-1:0] a_h, b_v;
  logic [N-1:0][N-1:0]         av_h, bv_v;
  logic [N-1:0][N-1:0][AW-1:0] acc_w;
  logic                        unused_edge;

  assign accept   = in_valid & in_ready_q;
  assign klen_sat = (k_len > KW'(KMAX)) ? KW'(KMAX) : k_len;
  assign row_nx   = row_q + RW'(1);

  // Input register: the valid tag is the handshake itself, so bubbles never accumulate.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_in_q <= '0;
      b_in_q <= '0;
      v_in_q <= 1'b0;
    end else begin
      a_in_q <= a_col;
      b_in_q <= b_row;
      v_in_q <= accept;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_skew
    if (i == 0) begin : g_direct
      assign a_sk[0] = a_in_q[0];
      assign b_sk[0] = b_in_q[0];
      assign v_sk[0] = v_in_q;
    end else begin : g_dly
      logic [i-1:0][DW-1:0] ad_q, ad_d, bd_q, bd_d;
      logic [i-1:0]         vd_q, vd_d;
      always_comb begin
        ad_d[0] = a_in_q[i];
        bd_d[0] = b_in_q[i];
        vd_d[0] = v_in_q;
        for (int s = 1; s < i; s++) begin
          ad_d[s] = ad_q[s-1];
          bd_d[s] = bd_q[s-1];
          vd_d[s] = vd_q[s-1];
        end
      end
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          ad_q <= '0;
          bd_q <= '0;
          vd_q <= '0;
        end else begin
          ad_q <= ad_d;
          bd_q <= bd_d;
          vd_q <= vd_d;
        end
      end
      assign a_sk[i] = ad_q[i-1];
      assign b_sk[i] = bd_q[i-1];
      assign v_sk[i] = vd_q[i-1];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [DW-1:0] a_in, b_in;
      logic          av_in, bv_in;
      if (j == 0) begin : g_al
        assign a_in  = a_sk[i];
        assign av_in = v_sk[i];
      end else begin : g_ah
        assign a_in  = a_h[i][j-1];
        assign av_in = av_h[i][j-1];
      end
      if (i == 0) begin : g_bt
        assign b_in  = b_sk[j];
        assign bv_in = v_sk[j];
      end else begin : g_bv
        assign b_in  = b_v[i-1][j];
        assign bv_in = bv_v[i-1][j];
      end
      sa_pe #(.DW(DW), .AW(AW), .SIGNED(SIGNED)) u_pe (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .a_i  (a_in),
        .b_i  (b_in),
        .av_i (av_in),
        .bv_i (bv_in),
        .a_o  (a_h[i][j]),
        .b_o  (b_v[i][j]),
        .av_o (av_h[i][j]),
        .bv_o (bv_v[i][j]),
        .acc_o(acc_w[i][j])
      );
    end
  end

  // The right column and bottom row forward into nothing.
  assign unused_edge = ^a_h ^ ^b_v ^ ^av_h ^ ^bv_v;

  always_comb begin
    state_d     = state_q;
    klen_d      = klen_q;
    kcnt_d      = kcnt_q;
    fcnt_d      = fcnt_q;
    row_d       = row_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;
    clr         = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        clr    = 1'b1;
        klen_d = klen_sat;
        kcnt_d = '0;
        row_d  = '0;
        if (klen_sat == '0) begin
          state_d = DRAIN;
        end else begin
          state_d    = LOAD;
          in_ready_d = 1'b1;
        end
      end
      LOAD: if (accept) begin
        kcnt_d = kcnt_q + KW'(1);
        if (kcnt_q == klen_q - KW'(1)) begin
          in_ready_d = 1'b0;
          fcnt_d     = '0;
          state_d    = FLUSH;
        end
      end
      // Long enough for the last beat to reach PE[N-1][N-1].
      FLUSH: begin
        if (fcnt_q == FW'(2 * N - 2)) state_d = DRAIN;
        else                          fcnt_d  = fcnt_q + FW'(1);
      end
      DRAIN: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = acc_w[0];
          row_d       = '0;
        end else if (out_ready) begin
          if (row_q == RW'(N - 1)) begin
            out_valid_d = 1'b0;
            done_d      = 1'b1;
            state_d     = IDLE;
          end else begin
            row_d      = row_nx;
            out_data_d = acc_w[row_nx];
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      klen_q      <= '0;
      kcnt_q      <= '0;
      fcnt_q      <= '0;
      row_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      klen_q      <= klen_d;
      kcnt_q      <= kcnt_d;
      fcnt_q      <= fcnt_d;
      row_q       <= row_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_row   = row_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
